// File: rtl/npu_tile_sched.sv
// Loop-nest sequencer for the NPU MAC array: walks a rows x cols grid of output
// tiles, issuing cfg_k accumulation beats, a pipeline drain and a writeback per tile.
module npu_tile_sched #(
  parameter int unsigned K_MAX     = 64,
  parameter int unsigned N_COL     = 8,
  parameter int unsigned N_ROW     = 8,
  parameter int unsigned DRAIN_CYC = 4,
  localparam int unsigned KW  = $clog2(K_MAX + 1),
  localparam int unsigned CW  = $clog2(N_COL + 1),
  localparam int unsigned RW  = $clog2(N_ROW + 1),
  localparam int unsigned KIW = (K_MAX > 1) ? $clog2(K_MAX) : 1,
  localparam int unsigned CIW = (N_COL > 1) ? $clog2(N_COL) : 1,
  localparam int unsigned RIW = (N_ROW > 1) ? $clog2(N_ROW) : 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [KW-1:0]  i_cfg_k,
  input  logic [CW-1:0]  i_cfg_cols,
  input  logic [RW-1:0]  i_cfg_rows,
  input  logic           i_stall,
  input  logic           i_wb_ready,
  output logic           o_busy,
  output logic           o_mac_en,
  output logic           o_acc_clear,
  output logic [KIW-1:0] o_k_idx,
  output logic [CIW-1:0] o_col_idx,
  output logic [RIW-1:0] o_row_idx,
  output logic           o_wb_valid,
  output logic           o_done,
  output logic           o_err
);

  localparam int unsigned DW         = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam int unsigned DRAIN_LAST = (DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPUTE,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [KIW-1:0] r_k_idx, w_k_nxt;
  logic [CIW-1:0] r_col, w_col_nxt;
  logic [RIW-1:0] r_row, w_row_nxt;
  logic [DW-1:0]  r_drain, w_drain_nxt;
  logic [KW-1:0]  r_cfg_k, w_cfg_k_nxt;
  logic [CW-1:0]  r_cfg_cols, w_cfg_cols_nxt;
  logic [RW-1:0]  r_cfg_rows, w_cfg_rows_nxt;
  logic           r_err_flag, w_err_flag_nxt;
  logic           r_busy, r_wb_valid, r_done, r_err;
  logic           w_mac_en;
  logic           w_cfg_ok;
  logic           w_k_last, w_col_last, w_row_last;

  // Bound compares run at the latched cfg width so cfg==max never overflows.
  assign w_k_last   = KW'(r_k_idx) == KW'(r_cfg_k - KW'(1));
  assign w_col_last = !(CW'(r_col) < CW'(r_cfg_cols - CW'(1)));
  assign w_row_last = !(RW'(r_row) < RW'(r_cfg_rows - RW'(1)));
  assign w_cfg_ok   = (i_cfg_k != '0)    && (i_cfg_k <= KW'(K_MAX)) &&
                      (i_cfg_cols != '0) && (i_cfg_cols <= CW'(N_COL)) &&
                      (i_cfg_rows != '0) && (i_cfg_rows <= RW'(N_ROW));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_k_idx    <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_drain    <= '0;
      r_cfg_k    <= '0;
      r_cfg_cols <= '0;
      r_cfg_rows <= '0;
      r_err_flag <= 1'b0;
      r_busy     <= 1'b0;
      r_wb_valid <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_k_idx    <= w_k_nxt;
      r_col      <= w_col_nxt;
      r_row      <= w_row_nxt;
      r_drain    <= w_drain_nxt;
      r_cfg_k    <= w_cfg_k_nxt;
      r_cfg_cols <= w_cfg_cols_nxt;
      r_cfg_rows <= w_cfg_rows_nxt;
      r_err_flag <= w_err_flag_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_wb_valid <= (w_state_nxt == S_WRITE);
      r_done     <= (w_state_nxt == S_DONE);
      r_err      <= (w_state_nxt == S_DONE) && w_err_flag_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_k_nxt        = r_k_idx;
    w_col_nxt      = r_col;
    w_row_nxt      = r_row;
    w_drain_nxt    = r_drain;
    w_cfg_k_nxt    = r_cfg_k;
    w_cfg_cols_nxt = r_cfg_cols;
    w_cfg_rows_nxt = r_cfg_rows;
    w_err_flag_nxt = r_err_flag;
    w_mac_en       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_cfg_k_nxt    = i_cfg_k;
          w_cfg_cols_nxt = i_cfg_cols;
          w_cfg_rows_nxt = i_cfg_rows;
          w_k_nxt        = '0;
          w_col_nxt      = '0;
          w_row_nxt      = '0;
          w_drain_nxt    = '0;
          w_err_flag_nxt = !w_cfg_ok;
          w_state_nxt    = w_cfg_ok ? S_COMPUTE : S_DONE;
        end
      end
      S_COMPUTE: begin
        w_mac_en = !i_stall;
        if (w_mac_en) begin
          if (w_k_last) begin
            w_k_nxt     = '0;
            w_drain_nxt = '0;
            w_state_nxt = (DRAIN_CYC == 0) ? S_WRITE : S_DRAIN;
          end else begin
            w_k_nxt = r_k_idx + KIW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (r_drain == DW'(DRAIN_LAST)) begin
          w_drain_nxt = '0;
          w_state_nxt = S_WRITE;
        end else begin
          w_drain_nxt = r_drain + DW'(1);
        end
      end
      S_WRITE: begin
        if (i_wb_ready) begin
          w_state_nxt = S_COMPUTE;
          if (!w_col_last) begin
            w_col_nxt = r_col + CIW'(1);
          end else begin
            w_col_nxt = '0;
            if (!w_row_last) begin
              w_row_nxt = r_row + RIW'(1);
            end else begin
              w_row_nxt   = '0;
              w_state_nxt = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        w_k_nxt     = '0;
        w_col_nxt   = '0;
        w_row_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Beat strobe follows stall within the cycle so a stalled beat is never issued.
  assign o_mac_en    = w_mac_en;
  assign o_acc_clear = w_mac_en && (r_k_idx == '0);
  assign o_k_idx     = r_k_idx;
  assign o_col_idx   = r_col;
  assign o_row_idx   = r_row;
  assign o_busy      = r_busy;
  assign o_wb_valid  = r_wb_valid;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: tb/tb_npu_tile_sched.sv
// Directed bench for npu_tile_sched with a writeback tile-order scoreboard.
module tb_npu_tile_sched;

  logic       clk = 1'b0;
  logic       rst, start, stall, wb_ready;
  logic [6:0] cfg_k;
  logic [3:0] cfg_cols, cfg_rows;
  logic       busy, mac_en, acc_clear, wb_valid, done, err;
  logic [5:0] k_idx;
  logic [2:0] col_idx, row_idx;

  int total = 0;
  int bad = 0;
  int mac_cnt = 0;
  int done_cnt = 0;

  typedef struct {
    int row;
    int col;
  } tile_t;
  tile_t sb[$];

  always #5 clk = ~clk;

  npu_tile_sched dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_cfg_k(cfg_k),
    .i_cfg_cols(cfg_cols), .i_cfg_rows(cfg_rows), .i_stall(stall),
    .i_wb_ready(wb_ready), .o_busy(busy), .o_mac_en(mac_en),
    .o_acc_clear(acc_clear), .o_k_idx(k_idx), .o_col_idx(col_idx),
    .o_row_idx(row_idx), .o_wb_valid(wb_valid), .o_done(done), .o_err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle monitor: beat/done counting, acc_clear rule, writeback order.
  task automatic mon();
    tile_t t;
    if (mac_en) mac_cnt++;
    if (done) done_cnt++;
    chk("acc_clear", 32'(acc_clear), 32'(mac_en && (k_idx == 6'd0)));
    if (wb_valid && wb_ready) begin
      if (sb.size() == 0) begin
        chk("wb_extra", 32'(sb.size()), 32'd1);
      end else begin
        t = sb.pop_front();
        chk("wb_row", 32'(row_idx), 32'(t.row));
        chk("wb_col", 32'(col_idx), 32'(t.col));
      end
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_mac"}, 32'(mac_en), 32'd0);
    chk({tag, "_accclr"}, 32'(acc_clear), 32'd0);
    chk({tag, "_wbv"}, 32'(wb_valid), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_k"}, 32'(k_idx), 32'd0);
    chk({tag, "_col"}, 32'(col_idx), 32'd0);
    chk({tag, "_row"}, 32'(row_idx), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; wb_ready = 1'b1;
    cfg_k = '0; cfg_cols = '0; cfg_rows = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk_all_zero("reset");
    clk_step();

    // Basic run: k=3, 2x1 grid
    cfg_k = 7'd3; cfg_cols = 4'd2; cfg_rows = 4'd1;
    sb.push_back('{0, 0}); sb.push_back('{0, 1});
    mac_cnt = 0; done_cnt = 0;
    for (int c = 0; c <= 18; c++) begin
      start = (c == 0);
      #1;
      if (c >= 1) begin
        chk("t1_mac", 32'(mac_en), 32'((c >= 1 && c <= 3) || (c >= 9 && c <= 11)));
        chk("t1_wbv", 32'(wb_valid), 32'(c == 8 || c == 16));
        chk("t1_done", 32'(done), 32'(c == 17));
        chk("t1_busy", 32'(busy), 32'(c <= 17));
        if (c == 17) chk("t1_err", 32'(err), 32'd0);
        if (c == 8 || c == 16) chk("t1_col", 32'(col_idx), 32'(c == 16));
      end
      mon();
      clk_step();
    end
    chk("t1_mac_cnt", 32'(mac_cnt), 32'd6);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);

    // Stall for two cycles while k_idx==2
    cfg_k = 7'd4; cfg_cols = 4'd1; cfg_rows = 4'd1;
    sb.push_back('{0, 0});
    mac_cnt = 0;
    for (int c = 0; c <= 13; c++) begin
      start = (c == 0);
      stall = (c == 3 || c == 4);
      #1;
      if (c >= 1) begin
        chk("t2_mac", 32'(mac_en), 32'(c == 1 || c == 2 || c == 5 || c == 6));
        chk("t2_wbv", 32'(wb_valid), 32'(c == 11));
        chk("t2_done", 32'(done), 32'(c == 12));
        if (c == 3 || c == 4) chk("t2_k_hold", 32'(k_idx), 32'd2);
      end
      mon();
      clk_step();
    end
    stall = 1'b0;
    chk("t2_mac_cnt", 32'(mac_cnt), 32'd4);

    // Writeback backpressure: wb_ready low for 5 WRITE cycles
    cfg_k = 7'd2; cfg_cols = 4'd2; cfg_rows = 4'd1;
    sb.push_back('{0, 0}); sb.push_back('{0, 1});
    mac_cnt = 0;
    for (int c = 0; c <= 21; c++) begin
      start = (c == 0);
      wb_ready = !(c >= 7 && c <= 11);
      #1;
      if (c >= 1) begin
        chk("t3_mac", 32'(mac_en), 32'(c == 1 || c == 2 || c == 13 || c == 14));
        chk("t3_wbv", 32'(wb_valid), 32'((c >= 7 && c <= 12) || c == 19));
        chk("t3_done", 32'(done), 32'(c == 20));
        if (wb_valid) begin
          chk("t3_col", 32'(col_idx), 32'(c >= 13));
          chk("t3_row", 32'(row_idx), 32'd0);
        end
      end
      mon();
      clk_step();
    end
    wb_ready = 1'b1;
    chk("t3_mac_cnt", 32'(mac_cnt), 32'd4);

    // Grid wrap 3x2, k=1, with start re-pulsed (bad cfg) while busy
    cfg_cols = 4'd3; cfg_rows = 4'd2;
    for (int r = 0; r < 2; r++)
      for (int cc = 0; cc < 3; cc++) sb.push_back('{r, cc});
    mac_cnt = 0; done_cnt = 0;
    for (int c = 0; c <= 38; c++) begin
      start = (c == 0) || (c >= 3 && c <= 5);
      cfg_k = (c >= 3) ? 7'd0 : 7'd1;
      #1;
      if (c >= 1) begin
        chk("t4_wbv", 32'(wb_valid), 32'(c >= 6 && c <= 36 && (c % 6) == 0));
        chk("t4_done", 32'(done), 32'(c == 37));
        if (c == 37) chk("t4_err", 32'(err), 32'd0);
        if (c == 38) chk_all_zero("t4_after");
      end
      mon();
      clk_step();
    end
    chk("t4_mac_cnt", 32'(mac_cnt), 32'd6);
    chk("t4_done_cnt", 32'(done_cnt), 32'd1);

    // Config errors: cfg_k=0, then cfg_cols=N_COL+1; start held into DONE
    for (int v = 0; v < 2; v++) begin
      cfg_k = (v == 0) ? 7'd0 : 7'd1;
      cfg_cols = (v == 0) ? 4'd1 : 4'd9;
      cfg_rows = 4'd1;
      for (int c = 0; c <= 3; c++) begin
        start = (c <= 1);
        #1;
        if (c >= 1) begin
          chk("t5_done", 32'(done), 32'(c == 1));
          chk("t5_err", 32'(err), 32'(c == 1));
          chk("t5_busy", 32'(busy), 32'(c == 1));
          chk("t5_mac", 32'(mac_en), 32'd0);
          chk("t5_wbv", 32'(wb_valid), 32'd0);
        end
        mon();
        clk_step();
      end
    end

    // Reset during DRAIN of the second tile, then a clean rerun
    cfg_k = 7'd2; cfg_cols = 4'd3; cfg_rows = 4'd1;
    for (int cc = 0; cc < 3; cc++) sb.push_back('{0, cc});
    done_cnt = 0;
    for (int c = 0; c <= 20; c++) begin
      start = (c == 0);
      rst = (c == 11);
      #1;
      if (c == 7) chk("t6_wbv", 32'(wb_valid), 32'd1);
      if (c >= 12) chk_all_zero("t6_rst");
      mon();
      clk_step();
    end
    rst = 1'b0;
    chk("t6_sb_left", 32'(sb.size()), 32'd2);
    chk("t6_no_done", 32'(done_cnt), 32'd0);
    sb.delete();
    for (int cc = 0; cc < 3; cc++) sb.push_back('{0, cc});
    mac_cnt = 0; done_cnt = 0;
    for (int c = 0; c <= 23; c++) begin
      start = (c == 0);
      #1;
      if (c >= 1) begin
        chk("t6r_wbv", 32'(wb_valid), 32'(c == 7 || c == 14 || c == 21));
        chk("t6r_done", 32'(done), 32'(c == 22));
      end
      mon();
      clk_step();
    end
    start = 1'b0;
    chk("t6r_mac_cnt", 32'(mac_cnt), 32'd6);
    chk("t6r_done_cnt", 32'(done_cnt), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
